// File: rtl/fetch_stall_controller.sv
// Front-end stall/flush sequencer for the fetch stage.
// Tracks outstanding instruction fetches and counts front-end stall cycles.
module fetch_stall_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_stall,
    input  logic        imem_done,
    input  logic        dmem_stall,
    input  logic        load_use,
    input  logic        branch_taken,
    input  logic        halt_decoded,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_bubble,
    output logic        imem_rd_en,
    output logic        halted,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        S_RUN,
        S_IWAIT,
        S_SQUASH,
        S_HALTED
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_done_pending;
    logic        w_done_pending_nxt;
    logic        w_done;
    logic [15:0] r_stall_cycles;

    assign w_done       = imem_done | r_done_pending;
    assign stall_cycles = r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_RUN;
            r_done_pending <= 1'b0;
            r_stall_cycles <= 16'd0;
        end else begin
            r_state        <= w_next;
            r_done_pending <= w_done_pending_nxt;
            if (!pc_en && (r_state != S_HALTED) && (r_stall_cycles != 16'hFFFF))
                r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    always_comb begin
        w_next             = r_state;
        w_done_pending_nxt = 1'b0;
        pc_en              = 1'b0;
        if_id_en           = 1'b0;
        if_id_flush        = 1'b0;
        id_bubble          = 1'b0;
        imem_rd_en         = 1'b0;
        halted             = 1'b0;
        if (rst) begin
            w_next = S_RUN;
        end else if (r_state == S_HALTED) begin
            halted = 1'b1;
        end else if (dmem_stall) begin
            // A fetch return seen while frozen is replayed once the freeze lifts.
            w_done_pending_nxt = r_done_pending |
                (imem_done && (r_state == S_IWAIT || r_state == S_SQUASH));
        end else begin
            unique case (r_state)
                S_RUN: begin
                    if (branch_taken) begin
                        pc_en       = 1'b1;
                        if_id_en    = 1'b1;
                        if_id_flush = 1'b1;
                        imem_rd_en  = 1'b1;
                        w_next      = imem_stall ? S_SQUASH : S_RUN;
                    end else if (load_use) begin
                        id_bubble = 1'b1;
                    end else if (imem_stall) begin
                        if_id_en    = 1'b1;
                        if_id_flush = 1'b1;
                        imem_rd_en  = 1'b1;
                        w_next      = S_IWAIT;
                    end else if (halt_decoded) begin
                        if_id_en    = 1'b1;
                        if_id_flush = 1'b1;
                        w_next      = S_HALTED;
                    end else begin
                        pc_en      = 1'b1;
                        if_id_en   = 1'b1;
                        imem_rd_en = 1'b1;
                    end
                end
                S_IWAIT: begin
                    if (branch_taken) begin
                        pc_en       = 1'b1;
                        if_id_en    = 1'b1;
                        if_id_flush = 1'b1;
                        w_next      = w_done ? S_RUN : S_SQUASH;
                    end else if (w_done) begin
                        pc_en    = 1'b1;
                        if_id_en = 1'b1;
                        w_next   = S_RUN;
                    end else begin
                        if_id_en    = 1'b1;
                        if_id_flush = 1'b1;
                    end
                end
                S_SQUASH: begin
                    if_id_en    = 1'b1;
                    if_id_flush = 1'b1;
                    if (w_done)
                        w_next = S_RUN;
                end
                default: begin
                    w_next = S_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stall_controller.sv
// Scoreboard bench for fetch_stall_controller.
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_fetch_stall_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_stall = 1'b0;
    logic        imem_done = 1'b0;
    logic        dmem_stall = 1'b0;
    logic        load_use = 1'b0;
    logic        branch_taken = 1'b0;
    logic        halt_decoded = 1'b0;
    logic        pc_en;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_bubble;
    logic        imem_rd_en;
    logic        halted;
    logic [15:0] stall_cycles;

    fetch_stall_controller dut (
        .clk          (clk),
        .rst          (rst),
        .imem_stall   (imem_stall),
        .imem_done    (imem_done),
        .dmem_stall   (dmem_stall),
        .load_use     (load_use),
        .branch_taken (branch_taken),
        .halt_decoded (halt_decoded),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .if_id_flush  (if_id_flush),
        .id_bubble    (id_bubble),
        .imem_rd_en   (imem_rd_en),
        .halted       (halted),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    // inputs: {rst, dmem, branch, load_use, imem_stall, imem_done, halt}
    localparam logic [6:0] I_NONE = 7'b0000000;
    localparam logic [6:0] I_RST  = 7'b1000000;
    localparam logic [6:0] I_DM   = 7'b0100000;
    localparam logic [6:0] I_BR   = 7'b0010000;
    localparam logic [6:0] I_LU   = 7'b0001000;
    localparam logic [6:0] I_IS   = 7'b0000100;
    localparam logic [6:0] I_DN   = 7'b0000010;
    localparam logic [6:0] I_HT   = 7'b0000001;

    // outputs: {pc_en, if_id_en, flush, bubble, rd_en, halted}
    localparam logic [5:0] O_ZERO = 6'b000000;
    localparam logic [5:0] O_NORM = 6'b110010;
    localparam logic [5:0] O_FLSH = 6'b011000;
    localparam logic [5:0] O_DONE = 6'b110000;
    localparam logic [5:0] O_BUB  = 6'b000100;
    localparam logic [5:0] O_BRR  = 6'b111010;
    localparam logic [5:0] O_BRW  = 6'b111000;
    localparam logic [5:0] O_HALT = 6'b000001;
    localparam logic [5:0] M_ALL  = 6'b111111;
    localparam logic [5:0] M_NORD = 6'b111101;

    typedef struct {
        logic [5:0]  exp;
        logic [5:0]  msk;
        logic [15:0] cnt;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic step(input logic [6:0] in, input logic [5:0] e,
                        input logic [5:0] m, input logic [15:0] c,
                        input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        {rst, dmem_stall, branch_taken, load_use,
         imem_stall, imem_done, halt_decoded} = in;
        x.exp = e;
        x.msk = m;
        x.cnt = c;
        x.nm  = nm;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            logic [5:0] w;
            x = q.pop_front();
            w = {pc_en, if_id_en, if_id_flush, id_bubble, imem_rd_en, halted};
            checks++;
            if ((w & x.msk) !== (x.exp & x.msk)) begin
                errors++;
                $display("FAIL %s outs got=%b want=%b mask=%b",
                         x.nm, w, x.exp, x.msk);
            end
            checks++;
            if (stall_cycles !== x.cnt) begin
                errors++;
                $display("FAIL %s stall_cycles got=%0d want=%0d",
                         x.nm, stall_cycles, x.cnt);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        step(I_RST,  O_ZERO, M_ALL,  16'd0,  "reset");
        step(I_NONE, O_NORM, M_ALL,  16'd0,  "idle1");
        step(I_NONE, O_NORM, M_ALL,  16'd0,  "idle2");
        step(I_NONE, O_NORM, M_ALL,  16'd0,  "idle3");
        step(I_IS,   O_FLSH, M_NORD, 16'd0,  "istall");
        step(I_NONE, O_FLSH, M_ALL,  16'd1,  "iwait");
        step(I_DN,   O_DONE, M_ALL,  16'd2,  "idone");
        step(I_NONE, O_NORM, M_ALL,  16'd2,  "after_done");
        step(I_IS,   O_FLSH, M_NORD, 16'd2,  "istall_b");
        step(I_BR,   O_BRW,  M_ALL,  16'd3,  "iwait_br");
        step(I_DN | I_BR | I_LU | I_HT, O_FLSH, M_ALL, 16'd3, "squash_done");
        step(I_NONE, O_NORM, M_ALL,  16'd4,  "after_squash");
        step(I_IS,   O_FLSH, M_NORD, 16'd4,  "istall_f");
        step(I_DM,   O_ZERO, M_ALL,  16'd5,  "freeze1");
        step(I_DM | I_DN, O_ZERO, M_ALL, 16'd6, "freeze2_done");
        step(I_DM,   O_ZERO, M_ALL,  16'd7,  "freeze3");
        step(I_DM,   O_ZERO, M_ALL,  16'd8,  "freeze4");
        step(I_NONE, O_DONE, M_ALL,  16'd9,  "pending_done");
        step(I_NONE, O_NORM, M_ALL,  16'd9,  "after_freeze");
        step(I_LU | I_IS, O_BUB, M_ALL, 16'd9, "lu_vs_istall");
        step(I_NONE, O_NORM, M_ALL,  16'd10, "after_lu");
        step(I_BR,   O_BRR,  M_ALL,  16'd10, "run_br");
        step(I_BR | I_IS, O_BRR, M_ALL, 16'd10, "run_br_is");
        step(I_NONE, O_FLSH, M_ALL,  16'd10, "squash_wait");
        step(I_DN,   O_FLSH, M_ALL,  16'd11, "squash_done2");
        step(I_NONE, O_NORM, M_ALL,  16'd12, "after_squash2");
        step(I_IS,   O_FLSH, M_NORD, 16'd12, "istall_c");
        step(I_BR | I_DN, O_BRW, M_ALL, 16'd13, "iwait_br_done");
        step(I_NONE, O_NORM, M_ALL,  16'd13, "after_brdone");
        step(I_DM | I_BR, O_ZERO, M_ALL, 16'd13, "run_freeze");
        step(I_NONE, O_NORM, M_ALL,  16'd14, "after_rfreeze");
        step(I_HT,   O_FLSH, M_ALL,  16'd14, "halt_dec");
        step(I_NONE, O_HALT, M_ALL,  16'd15, "halted1");
        step(I_DM,   O_HALT, M_ALL,  16'd15, "halted_dm");
        step(I_BR,   O_HALT, M_ALL,  16'd15, "halted_br");
        step(I_RST,  O_ZERO, M_ALL,  16'd15, "rst_halted");
        step(I_NONE, O_NORM, M_ALL,  16'd0,  "after_rst");
        step(I_BR | I_IS, O_BRR, M_ALL, 16'd0, "to_squash");
        step(I_RST,  O_ZERO, M_ALL,  16'd0,  "rst_squash");
        step(I_DN,   O_NORM, M_ALL,  16'd0,  "stale_done");
        step(I_IS,   O_FLSH, M_NORD, 16'd0,  "istall_d");
        step(I_DM | I_DN, O_ZERO, M_ALL, 16'd1, "freeze_pend");
        step(I_RST,  O_ZERO, M_ALL,  16'd2,  "rst_pend");
        step(I_IS,   O_FLSH, M_NORD, 16'd0,  "istall_e");
        step(I_NONE, O_FLSH, M_ALL,  16'd1,  "pend_cleared");
        step(I_DN,   O_DONE, M_ALL,  16'd2,  "idone_e");
        step(I_NONE, O_NORM, M_ALL,  16'd2,  "after_e");
        for (int i = 0; i < 65540; i++) begin
            int v;
            logic [15:0] c;
            v = 2 + i;
            c = (v > 65535) ? 16'hFFFF : v[15:0];
            step(I_LU, O_BUB, M_ALL, c, "sat_run");
        end
        step(I_NONE, O_NORM, M_ALL,  16'hFFFF, "sat_hold");
        step(I_LU,   O_BUB,  M_ALL,  16'hFFFF, "sat_nowrap");
        step(I_NONE, O_NORM, M_ALL,  16'hFFFF, "sat_final");
        @(posedge clk);
        #1;
        {rst, dmem_stall, branch_taken, load_use,
         imem_stall, imem_done, halt_decoded} = I_NONE;
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
